// File: rtl/rotator16_lr_reg.sv
// rotator16_lr_reg - registered barrel rotator.
//
// Rotates x left or right by 0..WIDTH-1 positions through a log2(WIDTH)
// stage mux network. The result is registered, so it appears one cycle
// after the operands are captured. One operation per cycle, no backpressure.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset (clears result/out_valid)
//   in_valid       operands valid this cycle
//   x              data to rotate
//   shift          rotate amount, unsigned
//   left_or_right  1 = rotate toward MSB, 0 = rotate toward LSB
//   shift_mode     (only with ROTATOR_LOGICAL_SHIFT_EN) 1 = logical shift,
//                  0 = rotate
//   result         registered rotated data; holds when in_valid=0
//   out_valid      registered valid
//
// Build option: define ROTATOR_LOGICAL_SHIFT_EN to add the shift_mode port
// and logical-shift support. Default build is a pure rotator.

module rotator16_lr_reg #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shift,
  input  logic               left_or_right,
`ifdef ROTATOR_LOGICAL_SHIFT_EN
  input  logic               shift_mode,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               out_valid
);

  // w_stage[0] is the raw operand; w_stage[k+1] is after stage k.
  logic [WIDTH-1:0] w_stage [0:SHAMT_W];
  logic             w_logical;

`ifdef ROTATOR_LOGICAL_SHIFT_EN
  assign w_logical = shift_mode;
`else
  assign w_logical = 1'b0;
`endif

  assign w_stage[0] = x;

  genvar k;
  generate
    for (k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [WIDTH-1:0] w_right;
      logic [WIDTH-1:0] w_left;

      // Wrapped-around bits are replaced by zeros in logical mode.
      always_comb begin
        w_right = {w_stage[k][S-1:0], w_stage[k][WIDTH-1:S]};
        w_left  = {w_stage[k][WIDTH-S-1:0], w_stage[k][WIDTH-1:WIDTH-S]};
        if (w_logical) begin
          w_right[WIDTH-1:WIDTH-S] = '0;
          w_left[S-1:0]            = '0;
        end
      end

      assign w_stage[k+1] = !shift[k]     ? w_stage[k] :
                            left_or_right ? w_left     : w_right;
    end
  endgenerate

  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_stage[SHAMT_W];
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rotator16_lr_reg.sv
module tb_rotator16_lr_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] x;
  logic [3:0]  shift;
  logic        left_or_right;
  logic        shift_mode;
  logic [15:0] result;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rotator16_lr_reg #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .x             (x),
    .shift         (shift),
    .left_or_right (left_or_right),
`ifdef ROTATOR_LOGICAL_SHIFT_EN
    .shift_mode    (shift_mode),
`endif
    .result        (result),
    .out_valid     (out_valid)
  );

  typedef struct {
    logic [15:0] x;
    logic [3:0]  sh;
    logic        left;
    logic [15:0] exp;
  } vec_t;

  // Behavioural reference: index arithmetic straight from the bit equations.
  function automatic logic [15:0] ref_rot(logic [15:0] d, int n, logic left, logic logical);
    logic [15:0] r;
    int src;
    for (int i = 0; i < 16; i++) begin
      src = left ? i - n : i + n;
      if (src >= 0 && src < 16) r[i] = d[src];
      else r[i] = logical ? 1'b0 : d[(src + 16) % 16];
    end
    return r;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one valid operation between edges and check it after the next edge.
  task automatic do_op(logic [15:0] dx, logic [3:0] sh, logic left, logic mode,
                       logic [15:0] exp, string name);
    @(negedge clk);
    in_valid = 1'b1; x = dx; shift = sh; left_or_right = left; shift_mode = mode;
    @(posedge clk); #1;
    check(name, result, exp);
    check({name, "_valid"}, {15'd0, out_valid}, 16'd1);
  endtask

  vec_t vecs [0:13];
  logic [15:0] last_exp;
  logic [15:0] r1;
  int vcount;

  initial begin
    vecs[0]  = '{16'h00FF, 4'd1,  1'b0, 16'h807F};
    vecs[1]  = '{16'h00FF, 4'd4,  1'b0, 16'hF00F};
    vecs[2]  = '{16'h00FF, 4'd8,  1'b0, 16'hFF00};
    vecs[3]  = '{16'h00FF, 4'd15, 1'b0, 16'h01FE};
    vecs[4]  = '{16'h00FF, 4'd1,  1'b1, 16'h01FE};
    vecs[5]  = '{16'h00FF, 4'd4,  1'b1, 16'h0FF0};
    vecs[6]  = '{16'h00FF, 4'd8,  1'b1, 16'hFF00};
    vecs[7]  = '{16'h00FF, 4'd15, 1'b1, 16'h807F};
    vecs[8]  = '{16'hF0F0, 4'd0,  1'b0, 16'hF0F0};
    vecs[9]  = '{16'hF0F0, 4'd0,  1'b1, 16'hF0F0};
    vecs[10] = '{16'hF0F0, 4'd4,  1'b0, 16'h0F0F};
    vecs[11] = '{16'hF0F0, 4'd1,  1'b1, 16'hE1E1};
    vecs[12] = '{16'h8001, 4'd2,  1'b0, 16'h6000};
    vecs[13] = '{16'h8001, 4'd3,  1'b1, 16'h000C};

    rst = 1'b1; in_valid = 1'b0; x = '0; shift = '0; left_or_right = 1'b0; shift_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_result", result, 16'h0000);
    check("idle_valid", {15'd0, out_valid}, 16'd0);

    // Required-value table
    for (int i = 0; i < 14; i++)
      do_op(vecs[i].x, vecs[i].sh, vecs[i].left, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back full sweeps in both directions
    for (int d = 0; d < 2; d++)
      for (int n = 1; n < 16; n++)
        do_op(16'h00FF, 4'(n), d[0], 1'b0, ref_rot(16'h00FF, n, d[0], 1'b0),
              $sformatf("sweep_d%0d_n%0d", d, n));

    // Valid gating: 3 valid ops, then idle; count valid cycles
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = (i < 3);
      x = 16'h1234 + 16'(i * 16'h1111);
      shift = 4'(i + 3);
      left_or_right = i[0];
      if (i == 2) last_exp = ref_rot(x, i + 3, i[0], 1'b0);
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    check("gate_valid_count", 16'(vcount), 16'd3);
    check("gate_result_hold", result, last_exp);
    check("gate_valid_low", {15'd0, out_valid}, 16'd0);

    // Random sweep: model compare, popcount, left(n) == right(16-n)
    for (int i = 0; i < 150; i++) begin
      logic [15:0] rx;
      int n;
      logic dir;
      rx = 16'($urandom);
      n = $urandom_range(1, 15);
      dir = 1'($urandom);
      do_op(rx, 4'(n), dir, 1'b0, ref_rot(rx, n, dir, 1'b0), "rand");
      check("rand_popcount", 16'($countones(result)), 16'($countones(rx)));
      r1 = result;
      do_op(rx, 4'(16 - n), 1'b0, 1'b0, ref_rot(rx, 16 - n, 1'b0, 1'b0), "rand_right");
      check("rand_l_eq_r", result, ref_rot(rx, n, 1'b1, 1'b0));
      if (dir) check("rand_equiv_prev", r1, result);
    end

    // Asynchronous reset mid-cycle with operands streaming
    do_op(16'hA5A5, 4'd3, 1'b1, 1'b0, ref_rot(16'hA5A5, 3, 1'b1, 1'b0), "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; x = 16'hBEEF; shift = 4'd5;
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", result, 16'h0000);
    check("async_rst_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;
    check("rst_held_result", result, 16'h0000);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", {15'd0, out_valid}, 16'd0);
    check("post_rst_result", result, 16'h0000);
    do_op(16'hBEEF, 4'd5, 1'b0, 1'b0, ref_rot(16'hBEEF, 5, 1'b0, 1'b0), "post_rst_op");

`ifdef ROTATOR_LOGICAL_SHIFT_EN
    do_op(16'h00FF, 4'd4,  1'b0, 1'b1, 16'h000F, "lsr4");
    do_op(16'h00FF, 4'd4,  1'b1, 1'b1, 16'h0FF0, "lsl4");
    do_op(16'h00FF, 4'd12, 1'b1, 1'b1, 16'hF000, "lsl12");
    do_op(16'h00FF, 4'd15, 1'b0, 1'b1, 16'h0000, "lsr15");
    do_op(16'h00FF, 4'd4,  1'b0, 1'b0, 16'hF00F, "mode0_r4");
    do_op(16'h00FF, 4'd15, 1'b1, 1'b0, 16'h807F, "mode0_l15");
    for (int i = 0; i < 60; i++) begin
      logic [15:0] rx;
      int n;
      logic dir;
      rx = 16'($urandom);
      n = $urandom_range(0, 15);
      dir = 1'($urandom);
      do_op(rx, 4'(n), dir, 1'b1, ref_rot(rx, n, dir, 1'b1), "rand_logical");
    end
`endif

    @(negedge clk); in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotator16_lr_reg.md
Name: rotator16_lr_reg

Overview:
- Registered 16-bit barrel rotator.
- Rotates a data word left or right by 0..15 bit positions. Bits shifted out of one end re-enter at the other.
- Sits in the datapath as a single-cycle operator stage: it captures operands on one clock edge and presents the result from the next edge.
- Fully synthesizable, built as a log2(WIDTH)-stage mux network followed by an output register.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two >= 2.
- SHAMT_W, 4, rotate-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- x  input  WIDTH  data to rotate.
- shift  input  SHAMT_W  rotate amount, unsigned, 0..WIDTH-1.
- left_or_right  input  1  direction: 1 = rotate left (toward MSB), 0 = rotate right (toward LSB).
- result  output  WIDTH  rotated data, registered.
- out_valid  output  1  result valid, registered.
- Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: while rst=1, result=0 and out_valid=0, regardless of clk. Reset takes effect immediately on assertion, not at the next edge.
- Operand capture:
  - On each rising clk edge with rst=0 and in_valid=1: result <= rot(x, shift, left_or_right) and out_valid <= 1.
  - On each rising clk edge with rst=0 and in_valid=0: out_valid <= 0 and result holds its previous value.
- Latency: exactly 1 cycle from operand capture to result. Throughput is one operation per cycle. There is no backpressure.
- Rotate right by n: result[i] = x[(i+n) mod WIDTH].
- Rotate left by n: result[i] = x[(i-n) mod WIDTH].
- shift=0: result = x, in either direction.
- Left by n equals right by (WIDTH-n), for n = 1..WIDTH-1.
- Bit conservation: rotation never loses bits, so the popcount of result always equals the popcount of x.
- Combinational core:
  - Stage k (k = 0..SHAMT_W-1) rotates by 2^k when shift[k]=1.
  - Direction is applied at every stage. No bit-reversal tricks are required, but they are permitted if results match.
- The shift port has exactly SHAMT_W bits, so no out-of-range amount is possible.
- Reset mid-stream: asserting rst while operands are arriving discards the in-flight result. After release, the first capture occurs on the first rising edge with rst=0 and in_valid=1.
- X/Z on inputs when in_valid=0 must not affect result.

Optional Feature:
- Macro: ROTATOR_LOGICAL_SHIFT_EN.
- When defined:
  - Adds input port shift_mode (1 bit), captured together with the other operands.
  - shift_mode=1 performs a logical shift instead of a rotate: vacated bit positions fill with 0 and bits shifted out are discarded.
  - Right by n: result[i] = x[i+n] if i+n < WIDTH, else 0.
  - Left by n: result[i] = x[i-n] if i >= n, else 0.
  - shift_mode=0 behaves as the plain rotator.
- When not defined: the shift_mode port does not exist and the block always rotates.

Test Plan:
- Reset: assert rst asynchronously between edges -> result=0x0000 and out_valid=0 immediately; after release with no in_valid, both stay 0.
- Right sweep: x=0x00FF, left_or_right=0, shift=1..15, one per cycle -> results arrive one cycle later with out_valid=1. Required values:
  - shift=1 -> 0x807F
  - shift=4 -> 0xF00F
  - shift=8 -> 0xFF00
  - shift=15 -> 0x01FE
- Left sweep: x=0x00FF, left_or_right=1, shift=1..15. Required values:
  - shift=1 -> 0x01FE
  - shift=4 -> 0x0FF0
  - shift=8 -> 0xFF00
  - shift=15 -> 0x807F
- Identity and pattern: shift=0 with x=0xF0F0 in both directions -> 0xF0F0. With x=0xF0F0:
  - right 4 -> 0x0F0F
  - left 1 -> 0xE1E1
- Valid gating: back-to-back in_valid=1 for 3 cycles, then in_valid=0 -> out_valid is high for exactly 3 cycles and result holds the last value afterwards. A random sweep of x and shift checks the popcount invariant and the left(n)=right(16-n) equivalence.
- Optional feature (with ROTATOR_LOGICAL_SHIFT_EN, shift_mode=1), x=0x00FF:
  - right 4 -> 0x000F
  - left 4 -> 0x0FF0
  - left 12 -> 0xF000
  - right 15 -> 0x0000
  - shift_mode=0 reproduces the rotate results above.
